// File: rtl/timer_arb_pkg.sv
// Shared definitions for the timer arbiter: FSM encoding, default sizing and
// the index-width helper used by timer_arb and rr_pick.
package timer_arb_pkg;

   typedef enum logic {
      TA_IDLE = 1'b0,
      TA_RUN  = 1'b1
   } ta_state_e;

   localparam int TA_NREQ_DEF  = 4;
   localparam int TA_WIDTH_DEF = 16;

   // Width of a requester index; never below 1 so ports stay legal.
   function automatic int ta_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : timer_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr.
// With TIMER_ARB_PRIO_EN defined, req[0] wins outright and is removed from the RR walk.
module rr_pick
   import timer_arb_pkg::*;
#(
   parameter  int NREQ = TA_NREQ_DEF,
   localparam int IW   = ta_idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   win_idx,
   output logic            win_vld
);

   logic [NREQ-1:0] cand;
   int              j;

   always_comb begin
      // NOTE: every output and temporary gets a default first, so no path through
      // this block leaves a value unassigned and no latch is inferred.
      win     = '0;
      win_idx = '0;
      win_vld = 1'b0;
      cand    = req;
      j       = 0;
`ifdef TIMER_ARB_PRIO_EN
      if (req[0]) begin
         win[0]  = 1'b1;
         win_vld = 1'b1;
      end
      cand[0] = 1'b0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!win_vld && cand[j]) begin
            win[j]  = 1'b1;
            win_idx = IW'(j);
            win_vld = 1'b1;
         end
      end
   end

endmodule : rr_pick

// File: rtl/timer_arb.sv
// One shared up-counter timer granted round-robin to NREQ one-shot delay requesters.
// Define TIMER_ARB_PRIO_EN to give requester 0 absolute priority over the RR group.
module timer_arb
   import timer_arb_pkg::*;
#(
   parameter int NREQ  = TA_NREQ_DEF,
   parameter int WIDTH = TA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] top,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [WIDTH-1:0]      cnt
);

   localparam int IW = ta_idx_w(NREQ);

   ta_state_e        state;
   logic [WIDTH-1:0] top_q;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    owner;

   logic [NREQ-1:0]  pick_oh;
   logic [IW-1:0]    pick_idx;
   logic             pick_vld;
   logic             owner_req;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .req     (req),
      .ptr     (ptr),
      .win     (pick_oh),
      .win_idx (pick_idx),
      .win_vld (pick_vld)
   );

   // grant is one-hot on the owner while running, so this is req[owner].
   assign owner_req = |(req & grant);

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= TA_IDLE;
         grant <= '0;
         done  <= '0;
         busy  <= 1'b0;
         cnt   <= '0;
         top_q <= '0;
         ptr   <= '0;
         owner <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here sees
         // its peers' pre-edge values regardless of statement order.
         done <= '0;
         case (state)
            TA_IDLE: begin
               if (pick_vld) begin
                  grant <= pick_oh;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  top_q <= top[int'(pick_idx)*WIDTH +: WIDTH];
                  owner <= pick_idx;
                  state <= TA_RUN;
               end
            end
            TA_RUN: begin
               if (!owner_req || (cnt == top_q)) begin
                  // Abort wins over completion: done only if the request survived.
                  if (owner_req) done <= grant;
                  grant <= '0;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= TA_IDLE;
`ifdef TIMER_ARB_PRIO_EN
                  if (owner != '0) ptr <= next_idx(owner);
`else
                  ptr <= next_idx(owner);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= TA_IDLE;
         endcase
      end
   end

endmodule : timer_arb
